// File: rtl/pkg_ppu.sv
// Shared PPU definitions: forwarding selects, sequencer states, PC register index.
package pkg_ppu;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // A used source register matches a destination; the PC is never a hazard source.
    function automatic logic src_hit(input logic [3:0] src, input logic used,
                                     input logic [3:0] rd);
        return used && (src != REG_PC) && (src == rd);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority mux for one ID source register; also flags a load-use hit.
module fwd_select
    import pkg_ppu::*;
(
    input  logic [3:0] src,
    input  logic       src_use,
    input  logic [3:0] exe_rd,
    input  logic       exe_rf_en,
    input  logic       exe_load,
    input  logic [3:0] mem_rd,
    input  logic       mem_rf_en,
    input  logic [3:0] wb_rd,
    input  logic       wb_rf_en,
    output logic [1:0] fwd,
    output logic       load_hit
);

    // Youngest producing stage wins; a load in EXE has no result yet.
    always_comb begin
        fwd = FWD_RF;
        if (src_hit(src, src_use, exe_rd) && exe_rf_en && !exe_load) begin
            fwd = FWD_EXE;
        end else if (src_hit(src, src_use, mem_rd) && mem_rf_en) begin
            fwd = FWD_MEM;
        end else if (src_hit(src, src_use, wb_rd) && wb_rf_en) begin
            fwd = FWD_WB;
        end
    end

    assign load_hit = src_hit(src, src_use, exe_rd) && exe_rf_en && exe_load;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer: boot hold, debug halt, load-use stall, branch flush,
// operand forwarding and saturating stall/flush event counters.
module hazard_ctrl_unit
    import pkg_ppu::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic             id_rn_use,
    input  logic [3:0]       id_rm,
    input  logic             id_rm_use,
    input  logic [3:0]       id_rd,
    input  logic             id_rd_use,
    input  logic [3:0]       exe_rd,
    input  logic             exe_rf_en,
    input  logic             exe_load,
    input  logic [3:0]       mem_rd,
    input  logic             mem_rf_en,
    input  logic [3:0]       wb_rd,
    input  logic             wb_rf_en,
    input  logic             id_br_taken,
    input  logic             halt,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             nop_sel,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t           state_q;
    logic [3:0]       boot_ctr_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             hit_a, hit_b, hit_c;
    logic             load_use;

    fwd_select u_fwd_a (
        .src(id_rn), .src_use(id_rn_use),
        .exe_rd(exe_rd), .exe_rf_en(exe_rf_en), .exe_load(exe_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .fwd(fwd_a), .load_hit(hit_a)
    );

    fwd_select u_fwd_b (
        .src(id_rm), .src_use(id_rm_use),
        .exe_rd(exe_rd), .exe_rf_en(exe_rf_en), .exe_load(exe_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .fwd(fwd_b), .load_hit(hit_b)
    );

    fwd_select u_fwd_c (
        .src(id_rd), .src_use(id_rd_use),
        .exe_rd(exe_rd), .exe_rf_en(exe_rf_en), .exe_load(exe_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .fwd(fwd_c), .load_hit(hit_c)
    );

    assign load_use = hit_a | hit_b | hit_c;

    // Mealy pipeline controls from state and current hazards.
    always_comb begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        nop_sel    = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (load_use) begin
                    // Stall wins; a pending branch is re-evaluated next cycle.
                    pc_le   = 1'b0;
                    ifid_le = 1'b0;
                    nop_sel = 1'b1;
                end else if (id_br_taken) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_HALT: begin
                pc_le   = 1'b0;
                ifid_le = 1'b0;
                nop_sel = 1'b1;
            end
            default: begin
                pc_le      = 1'b0;
                ifid_le    = 1'b0;
                nop_sel    = 1'b1;
                ifid_flush = 1'b1;
            end
        endcase
    end

    // State, boot countdown and saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            boot_ctr_q  <= 4'(BOOT_CYCLES);
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt) begin
                        state_q <= ST_HALT;
                    end
                    if (load_use) begin
                        if (stall_cnt_q != '1) begin
                            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        end
                    end else if (id_br_taken) begin
                        if (flush_cnt_q != '1) begin
                            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    // BOOT lasts BOOT_CYCLES cycles (at least one).
                    if (boot_ctr_q <= 4'd1) begin
                        state_q <= ST_RUN;
                    end
                    if (boot_ctr_q != 4'd0) begin
                        boot_ctr_q <= boot_ctr_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with CNT_W=4 so saturation is reachable.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_rn, id_rm, id_rd, exe_rd, mem_rd, wb_rd;
    logic       id_rn_use, id_rm_use, id_rd_use;
    logic       exe_rf_en, exe_load, mem_rf_en, wb_rf_en;
    logic       id_br_taken, halt;
    logic       pc_le, ifid_le, nop_sel, ifid_flush;
    logic [1:0] fwd_a, fwd_b, fwd_c;
    logic [3:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_unit #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rn_use(id_rn_use),
        .id_rm(id_rm), .id_rm_use(id_rm_use),
        .id_rd(id_rd), .id_rd_use(id_rd_use),
        .exe_rd(exe_rd), .exe_rf_en(exe_rf_en), .exe_load(exe_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
        .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .id_br_taken(id_br_taken), .halt(halt),
        .pc_le(pc_le), .ifid_le(ifid_le), .nop_sel(nop_sel), .ifid_flush(ifid_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
        id_rn_use = 1'b0; id_rm_use = 1'b0; id_rd_use = 1'b0;
        exe_rd = 4'd0; exe_rf_en = 1'b0; exe_load = 1'b0;
        mem_rd = 4'd0; mem_rf_en = 1'b0;
        wb_rd = 4'd0; wb_rf_en = 1'b0;
        id_br_taken = 1'b0; halt = 1'b0;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rn(input logic [3:0] r);
        exe_load = 1'b1; exe_rf_en = 1'b1; exe_rd = r;
        id_rn = r; id_rn_use = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // 1: reset held three edges, then two BOOT cycles, then RUN
        repeat (3) tick();
        check("rst_nop_sel", nop_sel, 1);
        check("rst_pc_le", pc_le, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0;
        #1;
        check("boot1_pc_le", pc_le, 0);
        check("boot1_ifid_le", ifid_le, 0);
        check("boot1_nop_sel", nop_sel, 1);
        check("boot1_flush", ifid_flush, 1);
        tick();
        check("boot2_pc_le", pc_le, 0);
        check("boot2_nop_sel", nop_sel, 1);
        tick();
        check("run_pc_le", pc_le, 1);
        check("run_ifid_le", ifid_le, 1);
        check("run_nop_sel", nop_sel, 0);
        check("run_flush", ifid_flush, 0);

        // 2: load-use on rn, then forward from MEM
        load_use_rn(4'd3);
        #1;
        check("lu_pc_le", pc_le, 0);
        check("lu_ifid_le", ifid_le, 0);
        check("lu_nop_sel", nop_sel, 1);
        check("lu_fwd_a", fwd_a, 2'b00);
        tick();
        check("lu_stall_cnt", stall_cnt, 1);
        idle();
        id_rn = 4'd3; id_rn_use = 1'b1; mem_rd = 4'd3; mem_rf_en = 1'b1;
        #1;
        check("lu_mem_fwd_a", fwd_a, 2'b10);
        check("lu_after_pc_le", pc_le, 1);

        // 3: forwarding priority on rm, use gating on rn, store-data on rd
        idle();
        exe_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
        exe_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
        id_rm = 4'd5; id_rm_use = 1'b1;
        id_rn = 4'd5; id_rn_use = 1'b0;
        id_rd = 4'd5; id_rd_use = 1'b1;
        #1;
        check("fwd_b_exe", fwd_b, 2'b01);
        check("fwd_a_unused", fwd_a, 2'b00);
        check("fwd_c_exe", fwd_c, 2'b01);
        exe_rf_en = 1'b0;
        #1;
        check("fwd_b_mem", fwd_b, 2'b10);
        mem_rf_en = 1'b0;
        #1;
        check("fwd_b_wb", fwd_b, 2'b11);
        check("fwd_c_wb", fwd_c, 2'b11);
        wb_rf_en = 1'b0;
        #1;
        check("fwd_b_rf", fwd_b, 2'b00);
        tick();
        check("fwd_no_stall_cnt", stall_cnt, 1);

        // 4: branch flush, then branch with load-use
        idle();
        id_br_taken = 1'b1;
        #1;
        check("br_flush", ifid_flush, 1);
        check("br_pc_le", pc_le, 1);
        check("br_nop_sel", nop_sel, 0);
        tick();
        check("br_flush_cnt", flush_cnt, 1);
        load_use_rn(4'd7);
        id_rn = 4'd0; id_rn_use = 1'b0;
        id_rm = 4'd7; id_rm_use = 1'b1;
        #1;
        check("brlu_flush", ifid_flush, 0);
        check("brlu_pc_le", pc_le, 0);
        check("brlu_nop_sel", nop_sel, 1);
        tick();
        check("brlu_flush_cnt", flush_cnt, 1);
        check("brlu_stall_cnt", stall_cnt, 2);

        // 5: halt for four cycles; hazards during HALT are not counted
        idle();
        halt = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) begin
                load_use_rn(4'd2);
                id_br_taken = 1'b1;
            end
            if (i == 4) begin
                halt = 1'b0;
            end
            #1;
            check("halt_pc_le", pc_le, 0);
            check("halt_nop_sel", nop_sel, 1);
            check("halt_flush", ifid_flush, 0);
            tick();
        end
        idle();
        #1;
        check("unhalt_pc_le", pc_le, 1);
        check("halt_stall_cnt", stall_cnt, 2);
        check("halt_flush_cnt", flush_cnt, 1);

        // PC as source never stalls or forwards
        load_use_rn(4'd15);
        #1;
        check("pc_src_pc_le", pc_le, 1);
        check("pc_src_fwd_a", fwd_a, 2'b00);
        exe_load = 1'b0;
        #1;
        check("pc_src_exe_fwd_a", fwd_a, 2'b00);
        tick();
        check("pc_src_stall_cnt", stall_cnt, 2);

        // 6: saturate stall_cnt, then reset from HALT
        idle();
        load_use_rn(4'd4);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 11) check("sat_pre_cnt", stall_cnt, 4'hE);
        end
        check("sat_stall_cnt", stall_cnt, 4'hF);
        idle();
        halt = 1'b1;
        tick();
        #1;
        check("pre_rst_halt_flush", ifid_flush, 0);
        reset = 1'b1;
        tick();
        check("rst_halt_flush", ifid_flush, 1);
        check("rst_halt_stall_cnt", stall_cnt, 0);
        check("rst_halt_flush_cnt", flush_cnt, 0);
        reset = 1'b0;
        halt = 1'b0;
        #1;
        check("reboot1_pc_le", pc_le, 0);
        tick();
        check("reboot2_pc_le", pc_le, 0);
        tick();
        check("reboot_run_pc_le", pc_le, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
